tlul_host_adapter: RTL and testbench

TLUL_HOST_ADAPTER -- requirements
Module: tlul_host_adapter

---
 rtl/tlul_host_adapter_if.sv | 65 ++++++
 rtl/tlul_host_adapter.sv | 142 ++++++++++++++
 tb/tb_tlul_host_adapter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_host_adapter_if.sv
// TL-UL type definitions and the bundled bus interface of the simple-bus to TL-UL host adapter.
// The package comes first so that the interface and the adapter can both use its types.
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef logic [13:0] tl_a_user_t;
    localparam tl_a_user_t TL_A_USER_DEFAULT = 14'h0;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [13:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

interface tlul_host_adapter_if;
    logic               req_i;
    logic               gnt_o;
    logic               we_i;
    logic [31:0]        addr_i;
    logic [31:0]        wdata_i;
    logic [3:0]         be_i;
    logic               rvalid_o;
    logic [31:0]        rdata_o;
    logic               err_o;
    tlul_pkg::tl_h2d_t  tl_o;
    tlul_pkg::tl_d2h_t  tl_i;

    // The slave side is the adapter itself; the master side is the local initiator plus the device.
    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, tl_i,
        output gnt_o, rvalid_o, rdata_o, err_o, tl_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, tl_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, tl_o
    );
endinterface

// File: rtl/tlul_host_adapter.sv
// Simple request/grant bus to TL-UL host adapter with up to Outstanding in-order requests in flight.
// The A channel is driven from a holding register; every D beat produces exactly one registered response.
module tlul_host_adapter #(
    parameter int Outstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    tlul_host_adapter_if.slave  bus
);
    import tlul_pkg::*;

    localparam int SrcW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int CntW = $clog2(Outstanding + 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(Outstanding);
    localparam logic [SrcW-1:0] LastSrc = SrcW'(Outstanding - 1);

    logic                 a_valid_q, a_valid_d;
    logic [2:0]           a_opcode_q, a_opcode_d;
    logic [31:0]          a_addr_q, a_addr_d;
    logic [3:0]           a_mask_q, a_mask_d;
    logic [31:0]          a_data_q, a_data_d;
    logic [SrcW-1:0]      a_source_q, a_source_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [SrcW-1:0]      alloc_ptr_q, alloc_ptr_d;
    logic [SrcW-1:0]      expect_ptr_q, expect_ptr_d;
    logic [(1<<SrcW)-1:0] we_fifo_q, we_fifo_d;
    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic gnt;
    logic d_fire;
    logic d_expected;
    logic exp_we;
    logic unused_bits;

    assign gnt = rst_ni & bus.req_i & (~a_valid_q | bus.tl_i.a_ready) & (cnt_q < MaxCnt);
    assign d_fire = bus.tl_i.d_valid;
    assign d_expected = d_fire & (cnt_q != '0);
    assign exp_we = we_fifo_q[expect_ptr_q];

    always_comb begin
        a_valid_d    = a_valid_q & ~bus.tl_i.a_ready;
        a_opcode_d   = a_opcode_q;
        a_addr_d     = a_addr_q;
        a_mask_d     = a_mask_q;
        a_data_d     = a_data_q;
        a_source_d   = a_source_q;
        alloc_ptr_d  = alloc_ptr_q;
        expect_ptr_d = expect_ptr_q;
        we_fifo_d    = we_fifo_q;
        cnt_d        = cnt_q;
        rvalid_d     = d_fire;
        rdata_d      = '0;
        err_d        = 1'b0;

        if (gnt) begin
            a_valid_d   = 1'b1;
            a_opcode_d  = !bus.we_i ? Get : ((bus.be_i == 4'hF) ? PutFullData : PutPartialData);
            a_addr_d    = {bus.addr_i[31:2], 2'b00};
            a_mask_d    = bus.we_i ? bus.be_i : 4'hF;
            a_data_d    = bus.we_i ? bus.wdata_i : 32'h0;
            a_source_d  = alloc_ptr_q;
            alloc_ptr_d = (alloc_ptr_q == LastSrc) ? '0 : alloc_ptr_q + 1'b1;
            we_fifo_d[alloc_ptr_q] = bus.we_i;
        end

        if (d_expected) begin
            expect_ptr_d = (expect_ptr_q == LastSrc) ? '0 : expect_ptr_q + 1'b1;
        end

        case ({gnt, d_expected})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // A beat arriving with nothing outstanding cannot be matched to a request, so it is flagged.
        if (d_expected) begin
            rdata_d = exp_we ? 32'h0 : bus.tl_i.d_data;
            err_d   = bus.tl_i.d_error
                    | (bus.tl_i.d_source != 8'(expect_ptr_q))
                    | (bus.tl_i.d_opcode != (exp_we ? AccessAck : AccessAckData));
        end else if (d_fire) begin
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_valid_q    <= 1'b0;
            a_opcode_q   <= '0;
            a_addr_q     <= '0;
            a_mask_q     <= '0;
            a_data_q     <= '0;
            a_source_q   <= '0;
            cnt_q        <= '0;
            alloc_ptr_q  <= '0;
            expect_ptr_q <= '0;
            we_fifo_q    <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            a_valid_q    <= a_valid_d;
            a_opcode_q   <= a_opcode_d;
            a_addr_q     <= a_addr_d;
            a_mask_q     <= a_mask_d;
            a_data_q     <= a_data_d;
            a_source_q   <= a_source_d;
            cnt_q        <= cnt_d;
            alloc_ptr_q  <= alloc_ptr_d;
            expect_ptr_q <= expect_ptr_d;
            we_fifo_q    <= we_fifo_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;

    assign bus.tl_o = '{
        a_valid:   a_valid_q,
        a_opcode:  a_opcode_q,
        a_param:   3'h0,
        a_size:    2'd2,
        a_source:  8'(a_source_q),
        a_address: a_addr_q,
        a_mask:    a_mask_q,
        a_data:    a_data_q,
        a_user:    TL_A_USER_DEFAULT,
        d_ready:   1'b1
    };

    assign unused_bits = ^{bus.addr_i[1:0], bus.tl_i.d_param, bus.tl_i.d_size,
                           bus.tl_i.d_sink, bus.tl_i.d_user};

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Self-checking bench for tlul_host_adapter: a table of single transactions followed by
// hand-written sequences for stalls, back-to-back issue, unsolicited beats and mid-flight reset.
module tb_tlul_host_adapter;
    import tlul_pkg::*;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] src_model = 8'h0;

    always #5 clk_i = ~clk_i;

    tlul_host_adapter_if bus();

    tlul_host_adapter #(.Outstanding(2)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [2:0]  d_opcode;
        logic        d_error;
        logic        bad_src;
        logic [31:0] d_data;
        logic [2:0]  exp_opcode;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_adata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        bus.req_i   = req;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        bus.be_i    = be;
        #1;
    endtask

    task automatic driveD(input logic valid, input logic [2:0] op, input logic [7:0] src,
                          input logic [31:0] data, input logic err);
        bus.tl_i.d_valid  = valid;
        bus.tl_i.d_opcode = op;
        bus.tl_i.d_source = src;
        bus.tl_i.d_data   = data;
        bus.tl_i.d_error  = err;
        #1;
    endtask

    function automatic logic [7:0] nextSrc(input logic [7:0] s);
        return (s == 8'd1) ? 8'd0 : 8'd1;
    endfunction

    task automatic runVector(input vec_t v, input int idx);
        logic [7:0] exp_src;
        applyStimulus(1'b1, v.we, v.addr, v.wdata, v.be);
        checkOutput($sformatf("v%0d.gnt", idx), 32'(bus.gnt_o), 32'd1);
        exp_src   = src_model;
        src_model = nextSrc(src_model);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput($sformatf("v%0d.a_valid", idx), 32'(bus.tl_o.a_valid), 32'd1);
        checkOutput($sformatf("v%0d.a_opcode", idx), 32'(bus.tl_o.a_opcode), 32'(v.exp_opcode));
        checkOutput($sformatf("v%0d.a_address", idx), bus.tl_o.a_address, v.exp_addr);
        checkOutput($sformatf("v%0d.a_mask", idx), 32'(bus.tl_o.a_mask), 32'(v.exp_mask));
        checkOutput($sformatf("v%0d.a_data", idx), bus.tl_o.a_data, v.exp_adata);
        checkOutput($sformatf("v%0d.a_source", idx), 32'(bus.tl_o.a_source), 32'(exp_src));
        checkOutput($sformatf("v%0d.a_size", idx), 32'(bus.tl_o.a_size), 32'd2);
        nextCycle();
        checkOutput($sformatf("v%0d.a_valid_drop", idx), 32'(bus.tl_o.a_valid), 32'd0);
        driveD(1'b1, v.d_opcode, v.bad_src ? 8'h07 : exp_src, v.d_data, v.d_error);
        nextCycle();
        driveD(1'b0, 3'h0, 8'h0, 32'h0, 1'b0);
        checkOutput($sformatf("v%0d.rvalid", idx), 32'(bus.rvalid_o), 32'd1);
        checkOutput($sformatf("v%0d.rdata", idx), bus.rdata_o, v.exp_rdata);
        checkOutput($sformatf("v%0d.err", idx), 32'(bus.err_o), 32'(v.exp_err));
        nextCycle();
        checkOutput($sformatf("v%0d.rvalid_pulse", idx), 32'(bus.rvalid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] s_a, s_b, s_c;

        // Fields: we, addr, wdata, be, d_opcode, d_error, bad_src, d_data,
        //         exp_opcode, exp_addr, exp_mask, exp_adata, exp_rdata, exp_err
        vecs[0] = '{1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, AccessAckData, 1'b0, 1'b0, 32'hDEAD_BEEF,
                    Get, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0013, 32'h1234_5678, 4'h3, AccessAck, 1'b0, 1'b0, 32'hAAAA_5555,
                    PutPartialData, 32'h0000_0010, 4'h3, 32'h1234_5678, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFE, 32'hCAFE_F00D, 4'hF, AccessAck, 1'b0, 1'b0, 32'h0BAD_F00D,
                    PutFullData, 32'hFFFF_FFFC, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 32'h2000_0007, 32'h5A5A_5A5A, 4'h3, AccessAckData, 1'b1, 1'b0, 32'h1111_1111,
                    Get, 32'h2000_0004, 4'hF, 32'h0, 32'h1111_1111, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, AccessAckData, 1'b0, 1'b1, 32'h2222_2222,
                    Get, 32'h0000_0040, 4'hF, 32'h0, 32'h2222_2222, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0044, 32'h0, 4'h0, AccessAck, 1'b0, 1'b0, 32'h3333_3333,
                    Get, 32'h0000_0044, 4'hF, 32'h0, 32'h3333_3333, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0008, 32'h8765_4321, 4'h8, AccessAckData, 1'b0, 1'b0, 32'h4444_4444,
                    PutPartialData, 32'h0000_0008, 4'h8, 32'h8765_4321, 32'h0, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_0100, 32'h0F0F_0F0F, 4'h0, AccessAck, 1'b0, 1'b0, 32'h5555_5555,
                    PutPartialData, 32'h0000_0100, 4'h0, 32'h0F0F_0F0F, 32'h0, 1'b0};

        bus.tl_i = '0;
        bus.tl_i.a_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        rst_ni = 1'b0;
        #2;
        checkOutput("reset.gnt", 32'(bus.gnt_o), 32'd0);
        checkOutput("reset.a_valid", 32'(bus.tl_o.a_valid), 32'd0);
        checkOutput("reset.rvalid", 32'(bus.rvalid_o), 32'd0);
        checkOutput("reset.rdata", bus.rdata_o, 32'd0);
        checkOutput("reset.err", 32'(bus.err_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();
        nextCycle();
        rst_ni = 1'b1;
        nextCycle();
        checkOutput("reset.d_ready", 32'(bus.tl_o.d_ready), 32'd1);

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            runVector(vecs[i], i);
        end

        $display("[TB] a_ready stall");
        bus.tl_i.a_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h204, 32'h55AA_55AA, 4'h5);
        checkOutput("stall.gnt0", 32'(bus.gnt_o), 32'd1);
        s_a = src_model;
        src_model = nextSrc(src_model);
        for (int k = 0; k < 5; k++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b0, 32'h300, 32'hFFFF_0000, 4'hF);
            checkOutput($sformatf("stall%0d.gnt", k), 32'(bus.gnt_o), 32'd0);
            checkOutput($sformatf("stall%0d.a_valid", k), 32'(bus.tl_o.a_valid), 32'd1);
            checkOutput($sformatf("stall%0d.a_opcode", k), 32'(bus.tl_o.a_opcode), 32'(PutPartialData));
            checkOutput($sformatf("stall%0d.a_address", k), bus.tl_o.a_address, 32'h204);
            checkOutput($sformatf("stall%0d.a_mask", k), 32'(bus.tl_o.a_mask), 32'h5);
            checkOutput($sformatf("stall%0d.a_data", k), bus.tl_o.a_data, 32'h55AA_55AA);
            checkOutput($sformatf("stall%0d.a_source", k), 32'(bus.tl_o.a_source), 32'(s_a));
        end
        nextCycle();
        bus.tl_i.a_ready = 1'b1;
        #1;
        checkOutput("stall.gnt_release", 32'(bus.gnt_o), 32'd1);
        s_b = src_model;
        src_model = nextSrc(src_model);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h308, 32'h0, 4'hF);
        checkOutput("stall.gnt_full", 32'(bus.gnt_o), 32'd0);
        checkOutput("stall.a2_opcode", 32'(bus.tl_o.a_opcode), 32'(Get));
        checkOutput("stall.a2_address", bus.tl_o.a_address, 32'h300);
        checkOutput("stall.a2_source", 32'(bus.tl_o.a_source), 32'(s_b));
        nextCycle();
        checkOutput("stall.gnt_full2", 32'(bus.gnt_o), 32'd0);
        checkOutput("stall.a_idle", 32'(bus.tl_o.a_valid), 32'd0);
        driveD(1'b1, AccessAck, s_a, 32'hDEAD_0000, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("stall.r1_valid", 32'(bus.rvalid_o), 32'd1);
        checkOutput("stall.r1_rdata", bus.rdata_o, 32'h0);
        checkOutput("stall.r1_err", 32'(bus.err_o), 32'd0);
        driveD(1'b1, AccessAckData, s_b, 32'h0000_CAFE, 1'b0);
        nextCycle();
        driveD(1'b0, 3'h0, 8'h0, 32'h0, 1'b0);
        checkOutput("stall.r2_valid", 32'(bus.rvalid_o), 32'd1);
        checkOutput("stall.r2_rdata", bus.rdata_o, 32'h0000_CAFE);
        checkOutput("stall.r2_err", 32'(bus.err_o), 32'd0);
        nextCycle();
        checkOutput("stall.r_idle", 32'(bus.rvalid_o), 32'd0);

        $display("[TB] back-to-back with full window");
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        checkOutput("b2b.gnt0", 32'(bus.gnt_o), 32'd1);
        s_a = src_model; src_model = nextSrc(src_model);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
        checkOutput("b2b.gnt1", 32'(bus.gnt_o), 32'd1);
        checkOutput("b2b.a0_source", 32'(bus.tl_o.a_source), 32'(s_a));
        checkOutput("b2b.a0_address", bus.tl_o.a_address, 32'h100);
        s_b = src_model; src_model = nextSrc(src_model);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h108, 32'h0, 4'h0);
        checkOutput("b2b.gnt2_stall", 32'(bus.gnt_o), 32'd0);
        checkOutput("b2b.a1_source", 32'(bus.tl_o.a_source), 32'(s_b));
        checkOutput("b2b.a1_address", bus.tl_o.a_address, 32'h104);
        nextCycle();
        checkOutput("b2b.gnt2_stall2", 32'(bus.gnt_o), 32'd0);
        checkOutput("b2b.a_idle", 32'(bus.tl_o.a_valid), 32'd0);
        driveD(1'b1, AccessAckData, s_a, 32'h0000_00A0, 1'b0);
        nextCycle();
        driveD(1'b0, 3'h0, 8'h0, 32'h0, 1'b0);
        checkOutput("b2b.r0_valid", 32'(bus.rvalid_o), 32'd1);
        checkOutput("b2b.r0_rdata", bus.rdata_o, 32'h0000_00A0);
        checkOutput("b2b.r0_err", 32'(bus.err_o), 32'd0);
        checkOutput("b2b.gnt2", 32'(bus.gnt_o), 32'd1);
        s_c = src_model; src_model = nextSrc(src_model);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("b2b.a2_valid", 32'(bus.tl_o.a_valid), 32'd1);
        checkOutput("b2b.a2_source", 32'(bus.tl_o.a_source), 32'(s_c));
        checkOutput("b2b.a2_source_zero", 32'(bus.tl_o.a_source), 32'd0);
        checkOutput("b2b.a2_address", bus.tl_o.a_address, 32'h108);
        driveD(1'b1, AccessAckData, s_b, 32'h0000_00A1, 1'b0);
        nextCycle();
        checkOutput("b2b.r1_valid", 32'(bus.rvalid_o), 32'd1);
        checkOutput("b2b.r1_rdata", bus.rdata_o, 32'h0000_00A1);
        checkOutput("b2b.r1_err", 32'(bus.err_o), 32'd0);
        driveD(1'b1, AccessAckData, s_c, 32'h0000_00A2, 1'b0);
        nextCycle();
        driveD(1'b0, 3'h0, 8'h0, 32'h0, 1'b0);
        checkOutput("b2b.r2_valid", 32'(bus.rvalid_o), 32'd1);
        checkOutput("b2b.r2_rdata", bus.rdata_o, 32'h0000_00A2);
        checkOutput("b2b.r2_err", 32'(bus.err_o), 32'd0);
        nextCycle();
        checkOutput("b2b.r_idle", 32'(bus.rvalid_o), 32'd0);

        $display("[TB] unsolicited beat");
        driveD(1'b1, AccessAckData, 8'h0, 32'h0000_0099, 1'b0);
        nextCycle();
        driveD(1'b0, 3'h0, 8'h0, 32'h0, 1'b0);
        checkOutput("unsol.rvalid", 32'(bus.rvalid_o), 32'd1);
        checkOutput("unsol.err", 32'(bus.err_o), 32'd1);
        checkOutput("unsol.rdata", bus.rdata_o, 32'h0);
        nextCycle();
        runVector(vecs[0], 100);

        $display("[TB] reset with requests in flight");
        applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        checkOutput("rst.gnt0", 32'(bus.gnt_o), 32'd1);
        s_a = src_model; src_model = nextSrc(src_model);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h404, 32'h0, 4'h0);
        checkOutput("rst.gnt1", 32'(bus.gnt_o), 32'd1);
        s_b = src_model; src_model = nextSrc(src_model);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h408, 32'h0, 4'h0);
        bus.tl_i.a_ready = 1'b0;
        checkOutput("rst.a1_valid", 32'(bus.tl_o.a_valid), 32'd1);
        driveD(1'b1, AccessAckData, s_a, 32'h0000_00BB, 1'b0);
        nextCycle();
        driveD(1'b0, 3'h0, 8'h0, 32'h0, 1'b0);
        checkOutput("rst.pre_rvalid", 32'(bus.rvalid_o), 32'd1);
        checkOutput("rst.pre_rdata", bus.rdata_o, 32'h0000_00BB);
        checkOutput("rst.pre_a_valid", 32'(bus.tl_o.a_valid), 32'd1);
        bus.tl_i.a_ready = 1'b1;
        #1;
        checkOutput("rst.pre_gnt", 32'(bus.gnt_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        checkOutput("rst.gnt", 32'(bus.gnt_o), 32'd0);
        checkOutput("rst.a_valid", 32'(bus.tl_o.a_valid), 32'd0);
        checkOutput("rst.rvalid", 32'(bus.rvalid_o), 32'd0);
        checkOutput("rst.rdata", bus.rdata_o, 32'h0);
        checkOutput("rst.err", 32'(bus.err_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();
        nextCycle();
        rst_ni = 1'b1;
        src_model = 8'h0;
        driveD(1'b1, AccessAckData, s_b, 32'h0000_00CC, 1'b0);
        nextCycle();
        driveD(1'b0, 3'h0, 8'h0, 32'h0, 1'b0);
        checkOutput("rst.late_rvalid", 32'(bus.rvalid_o), 32'd1);
        checkOutput("rst.late_err", 32'(bus.err_o), 32'd1);
        checkOutput("rst.late_rdata", bus.rdata_o, 32'h0);
        nextCycle();
        runVector(vecs[1], 101);
        runVector(vecs[0], 102);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
